// File: rtl/hello_rotator.sv
// Timed 3-bit rotation index (0..4) for the HELLO display character muxes.
// Supports free-running scroll, pause, direction, single-step and direct load.
module hello_rotator #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       Run,
  input  logic       Dir,
  input  logic       Step,
  input  logic       Load,
  input  logic [2:0] LoadVal,
  output logic [2:0] S,
  output logic       Tick
);

  localparam logic [2:0] ROT0 = 3'd0;
  localparam logic [2:0] ROT1 = 3'd1;
  localparam logic [2:0] ROT2 = 3'd2;
  localparam logic [2:0] ROT3 = 3'd3;
  localparam logic [2:0] ROT4 = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [2:0]       s_q, s_d;
  logic [2:0]       s_adv;
  logic [2:0]       load_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             step_q;
  logic             step_edge;
  logic             cnt_last;

  assign step_edge = Step & ~step_q;
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign load_s    = (LoadVal > ROT4) ? ROT0 : LoadVal;

  // Unreachable codes 5..7 fall back to ROT0 so S can never leave 0..4.
  always_comb begin
    s_adv = ROT0;
    case (s_q)
      ROT0:    s_adv = Dir ? ROT4 : ROT1;
      ROT1:    s_adv = Dir ? ROT0 : ROT2;
      ROT2:    s_adv = Dir ? ROT1 : ROT3;
      ROT3:    s_adv = Dir ? ROT2 : ROT4;
      ROT4:    s_adv = Dir ? ROT3 : ROT0;
      default: s_adv = ROT0;
    endcase
  end

  always_comb begin
    s_d    = s_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (Load) begin
      s_d   = load_s;
      cnt_d = '0;
    end else if (Run) begin
      if (cnt_last) begin
        cnt_d  = '0;
        s_d    = s_adv;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (step_edge) begin
      // Paused: prescaler holds so scrolling resumes mid-period.
      s_d    = s_adv;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      s_q    <= ROT0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      step_q <= Step;
    end
  end

  assign S    = s_q;
  assign Tick = tick_q;

endmodule
